// File: rtl/c2f_write_decoder_if.sv
// C2F write decoder bus: host register-write strobe in, command stream out,
// plus FIFO/error status. The decoder sits on the slave side.
interface c2f_write_decoder_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 rxRegValid_in;
  logic [7:0]           rxRegIdx_in;
  logic [31:0]          rxRegData_in;
  logic [31:0]          c2fAddr_out;
  logic [63:0]          c2fData_out;
  logic                 c2fValid_out;
  logic                 c2fReady_in;
  logic [LW-1:0]        fifoLevel_out;
  logic [CNT_WIDTH-1:0] overflowCount_out;
  logic                 seqError_out;
  logic                 clrErr_in;

  modport master (
    output rxRegValid_in, rxRegIdx_in, rxRegData_in, c2fReady_in, clrErr_in,
    input  c2fAddr_out, c2fData_out, c2fValid_out, fifoLevel_out,
           overflowCount_out, seqError_out
  );

  modport slave (
    input  rxRegValid_in, rxRegIdx_in, rxRegData_in, c2fReady_in, clrErr_in,
    output c2fAddr_out, c2fData_out, c2fValid_out, fifoLevel_out,
           overflowCount_out, seqError_out
  );
endinterface

// File: rtl/c2f_write_decoder.sv
// C2F write decoder: assembles ADDR (253) / LSW (254) / MSW (255) host
// register writes into 64-bit write commands, buffers them in a FWFT FIFO
// and presents them on a valid/ready stream. Address auto-increments after
// each MSW so the host can stream LSW/MSW pairs.
module c2f_write_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic               pcieClk_in,
  input  logic               pcieRstN_in,
  c2f_write_decoder_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [7:0] IDX_ADDR = 8'd253;
  localparam logic [7:0] IDX_LSW  = 8'd254;
  localparam logic [7:0] IDX_MSW  = 8'd255;

  typedef enum logic [1:0] {IDLE, GOT_ADDR, GOT_LSW} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } cmd_t;

  state_t               r_state, w_state_nx;
  logic [31:0]          r_addr, w_addr_nx;
  logic [31:0]          r_lsw, w_lsw_nx;
  logic                 w_push_req, w_seq_err;

  cmd_t                 r_mem [FIFO_DEPTH];
  cmd_t                 r_last;
  cmd_t                 w_head, w_cmd;
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [CNT_WIDTH-1:0] r_ovf;
  logic                 r_err;
  logic                 w_valid, w_full, w_pop, w_push, w_drop;

  // Command assembled from the MSW strobe plus held address and LSW
  assign w_cmd   = '{addr: r_addr, data: {bus.rxRegData_in, r_lsw}};
  assign w_head  = r_mem[r_rd_ptr];
  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_pop   = w_valid & bus.c2fReady_in;
  // A full FIFO still takes the command when the head leaves this cycle
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & ~w_push;

  // Sequence state, address and LSW holding registers
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_lsw   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_lsw   <= w_lsw_nx;
    end
  end

  // Protocol decode: next state, push request and sequence-error detection
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_lsw_nx   = r_lsw;
    w_push_req = 1'b0;
    w_seq_err  = 1'b0;
    if (bus.rxRegValid_in) begin
      case (bus.rxRegIdx_in)
        IDX_ADDR: begin
          // New address restarts the sequence; a held LSW is simply dropped
          w_addr_nx  = bus.rxRegData_in;
          w_state_nx = GOT_ADDR;
        end
        IDX_LSW: begin
          if (r_state == IDLE) begin
            w_seq_err = 1'b1;
          end else begin
            w_lsw_nx   = bus.rxRegData_in;
            w_state_nx = GOT_LSW;
          end
        end
        IDX_MSW: begin
          if (r_state == GOT_LSW) begin
            // Address advances even if the command gets dropped on overflow
            w_push_req = 1'b1;
            w_addr_nx  = r_addr + 32'd1;
            w_state_nx = GOT_ADDR;
          end else begin
            w_seq_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO storage; contents need no reset since valid is level-driven
  always_ff @(posedge pcieClk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cmd;
  end

  // FIFO pointers, occupancy and last-popped command for the empty case
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_last   <= w_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flag and saturating drop counter; a new event beats clear
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      r_err <= 1'b0;
      r_ovf <= '0;
    end else begin
      if (w_seq_err)          r_err <= 1'b1;
      else if (bus.clrErr_in) r_err <= 1'b0;

      if (w_drop) begin
        if (bus.clrErr_in)    r_ovf <= CNT_WIDTH'(1);
        else if (r_ovf != '1) r_ovf <= r_ovf + CNT_WIDTH'(1);
      end else if (bus.clrErr_in) begin
        r_ovf <= '0;
      end
    end
  end

  // Head falls through while valid; outputs hold the last popped command when empty
  assign bus.c2fValid_out      = w_valid;
  assign bus.c2fAddr_out       = w_valid ? w_head.addr : r_last.addr;
  assign bus.c2fData_out       = w_valid ? w_head.data : r_last.data;
  assign bus.fifoLevel_out     = r_level;
  assign bus.overflowCount_out = r_ovf;
  assign bus.seqError_out      = r_err;

endmodule

// File: tb/tb_c2f_write_decoder.sv
// Directed bench for c2f_write_decoder: a vector table for the streaming,
// wrap and error paths, then hand sequences for overflow, the full/pop
// boundary, clear priority, mid-sequence restarts and asynchronous reset.
module tb_c2f_write_decoder;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  c2f_write_decoder_if #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

  c2f_write_decoder #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .pcieClk_in  (clk),
    .pcieRstN_in (rst_n),
    .bus         (bus.slave)
  );

  typedef struct {
    logic        v;
    logic [7:0]  idx;
    logic [31:0] d;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [31:0] ea;
    logic [63:0] ed;
    int          el;
    int          eo;
    logic        ee;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    bus.rxRegValid_in = 1'b0;
    bus.rxRegIdx_in   = 8'd0;
    bus.rxRegData_in  = 32'd0;
    bus.clrErr_in     = 1'b0;
  endtask

  // One clock with the given strobe; returns #1 after the edge
  task automatic wr(input logic [7:0] idx, input logic [31:0] d);
    bus.rxRegValid_in = 1'b1;
    bus.rxRegIdx_in   = idx;
    bus.rxRegData_in  = d;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.c2fReady_in = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string pre);
    chk({pre, "_valid"}, 64'(bus.c2fValid_out), 64'd0);
    chk({pre, "_level"}, 64'(bus.fifoLevel_out), 64'd0);
    chk({pre, "_ovf"},   64'(bus.overflowCount_out), 64'd0);
    chk({pre, "_err"},   64'(bus.seqError_out), 64'd0);
    chk({pre, "_addr"},  64'(bus.c2fAddr_out), 64'd0);
    chk({pre, "_data"},  bus.c2fData_out, 64'd0);
  endtask

  vec_t tbl [15];

  initial begin
    logic [31:0] base;
    logic [15:0] ovf_now;
    idle_inputs();
    bus.c2fReady_in = 1'b0;

    //          v   idx     data          rdy  clr  ev   addr          data                   lvl ovf err
    tbl[0]  = '{1, 8'd253, 32'h00000010, 0, 0, 0, 32'h0,        64'h0,                  0, 0, 0};
    tbl[1]  = '{1, 8'd254, 32'hDEADBEEF, 0, 0, 0, 32'h0,        64'h0,                  0, 0, 0};
    tbl[2]  = '{1, 8'd255, 32'h01234567, 0, 0, 1, 32'h00000010, 64'h01234567DEADBEEF,   1, 0, 0};
    tbl[3]  = '{0, 8'd0,   32'h0,        1, 0, 0, 32'h0,        64'h0,                  0, 0, 0};
    tbl[4]  = '{1, 8'd253, 32'hFFFFFFFF, 1, 0, 0, 32'h0,        64'h0,                  0, 0, 0};
    tbl[5]  = '{1, 8'd254, 32'hA0A0A0A0, 1, 0, 0, 32'h0,        64'h0,                  0, 0, 0};
    tbl[6]  = '{1, 8'd255, 32'hB0B0B0B0, 1, 0, 1, 32'hFFFFFFFF, 64'hB0B0B0B0A0A0A0A0,   1, 0, 0};
    tbl[7]  = '{1, 8'd254, 32'hA1A1A1A1, 1, 0, 0, 32'h0,        64'h0,                  0, 0, 0};
    tbl[8]  = '{1, 8'd255, 32'hB1B1B1B1, 1, 0, 1, 32'h00000000, 64'hB1B1B1B1A1A1A1A1,   1, 0, 0};
    tbl[9]  = '{1, 8'd254, 32'hA2A2A2A2, 1, 0, 0, 32'h0,        64'h0,                  0, 0, 0};
    tbl[10] = '{1, 8'd255, 32'hB2B2B2B2, 1, 0, 1, 32'h00000001, 64'hB2B2B2B2A2A2A2A2,   1, 0, 0};
    tbl[11] = '{0, 8'd0,   32'h0,        1, 0, 0, 32'h0,        64'h0,                  0, 0, 0};
    tbl[12] = '{1, 8'd7,   32'h12345678, 1, 0, 0, 32'h0,        64'h0,                  0, 0, 0};
    tbl[13] = '{1, 8'd255, 32'h55555555, 1, 0, 0, 32'h0,        64'h0,                  0, 0, 1};
    tbl[14] = '{0, 8'd0,   32'h0,        1, 1, 0, 32'h0,        64'h0,                  0, 0, 0};

    do_reset();
    chk_reset_vals("rst0");

    for (int i = 0; i < 15; i++) begin
      bus.rxRegValid_in = tbl[i].v;
      bus.rxRegIdx_in   = tbl[i].idx;
      bus.rxRegData_in  = tbl[i].d;
      bus.c2fReady_in   = tbl[i].rdy;
      bus.clrErr_in     = tbl[i].clr;
      tick();
      chk($sformatf("v%0d_valid", i), 64'(bus.c2fValid_out), 64'(tbl[i].ev));
      chk($sformatf("v%0d_level", i), 64'(bus.fifoLevel_out), 64'(tbl[i].el));
      chk($sformatf("v%0d_ovf", i),   64'(bus.overflowCount_out), 64'(tbl[i].eo));
      chk($sformatf("v%0d_err", i),   64'(bus.seqError_out), 64'(tbl[i].ee));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_addr", i), 64'(bus.c2fAddr_out), 64'(tbl[i].ea));
        chk($sformatf("v%0d_data", i), bus.c2fData_out, tbl[i].ed);
      end
    end
    idle_inputs();

    // MSW straight after reset
    do_reset();
    wr(8'd255, 32'h11111111);
    chk("msw_idle_valid", 64'(bus.c2fValid_out), 64'd0);
    chk("msw_idle_err",   64'(bus.seqError_out), 64'd1);
    // LSW in IDLE after a fresh reset, then clear
    do_reset();
    chk("err_after_rst", 64'(bus.seqError_out), 64'd0);
    wr(8'd254, 32'h22222222);
    chk("lsw_idle_err", 64'(bus.seqError_out), 64'd1);
    bus.clrErr_in = 1'b1; tick(); bus.clrErr_in = 1'b0;
    chk("clr_err", 64'(bus.seqError_out), 64'd0);

    // Overflow: 10 pairs into an 8-deep FIFO with no consumer
    do_reset();
    base = 32'h00000100;
    wr(8'd253, base);
    for (int i = 0; i < 10; i++) begin
      wr(8'd254, 32'(i));
      wr(8'd255, 32'h1000 + 32'(i));
    end
    chk("ovf_level", 64'(bus.fifoLevel_out), 64'd8);
    chk("ovf_count", 64'(bus.overflowCount_out), 64'd2);
    bus.c2fReady_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_valid", k), 64'(bus.c2fValid_out), 64'd1);
      chk($sformatf("drain%0d_addr", k),  64'(bus.c2fAddr_out), 64'(base + 32'(k)));
      chk($sformatf("drain%0d_data", k),  bus.c2fData_out, {32'h1000 + 32'(k), 32'(k)});
      tick();
    end
    chk("drain_done_valid", 64'(bus.c2fValid_out), 64'd0);
    chk("drain_done_level", 64'(bus.fifoLevel_out), 64'd0);
    bus.c2fReady_in = 1'b0;

    // Full boundary: address continues at base+10; refill to 8
    for (int i = 0; i < 8; i++) begin
      wr(8'd254, 32'h2000 + 32'(i));
      wr(8'd255, 32'h3000 + 32'(i));
    end
    chk("refill_level", 64'(bus.fifoLevel_out), 64'd8);
    chk("refill_head",  64'(bus.c2fAddr_out), 64'(base + 32'd10));
    wr(8'd254, 32'h000000AA);
    bus.c2fReady_in = 1'b1;
    wr(8'd255, 32'h000000BB);
    bus.c2fReady_in = 1'b0;
    chk("fullpop_level", 64'(bus.fifoLevel_out), 64'd8);
    chk("fullpop_ovf",   64'(bus.overflowCount_out), 64'd2);
    chk("fullpop_head",  64'(bus.c2fAddr_out), 64'(base + 32'd11));
    // Drop in the same cycle as clear: increment wins, count restarts at 1
    wr(8'd254, 32'h000000CC);
    bus.clrErr_in = 1'b1;
    wr(8'd255, 32'h000000DD);
    ovf_now = bus.overflowCount_out;
    chk("clr_vs_drop", 64'(ovf_now), 64'd1);
    bus.clrErr_in = 1'b1; tick(); bus.clrErr_in = 1'b0;
    chk("clr_ovf", 64'(bus.overflowCount_out), 64'd0);
    chk("clr_keep_level", 64'(bus.fifoLevel_out), 64'd8);

    // Unrelated index mid-sequence, then a fresh address discards the LSW
    do_reset();
    wr(8'd253, 32'h40);
    wr(8'd254, 32'h41);
    wr(8'd7,   32'h42);
    wr(8'd253, 32'h50);
    wr(8'd255, 32'h51);
    chk("restart_valid", 64'(bus.c2fValid_out), 64'd0);
    chk("restart_level", 64'(bus.fifoLevel_out), 64'd0);
    chk("restart_err",   64'(bus.seqError_out), 64'd1);

    // Asynchronous reset while in GOT_LSW with a command queued
    do_reset();
    wr(8'd253, 32'h60);
    wr(8'd254, 32'h61);
    wr(8'd255, 32'h62);
    wr(8'd254, 32'h63);
    chk("pre_rst_valid", 64'(bus.c2fValid_out), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wr(8'd255, 32'h64);
    chk("post_rst_valid", 64'(bus.c2fValid_out), 64'd0);
    chk("post_rst_err",   64'(bus.seqError_out), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: timeout, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/c2f_write_decoder.md
Name: c2f_write_decoder

Overview:
- Receive-side decoder for the host CPU-to-FPGA (C2F) write protocol.
- The host issues 32-bit register writes to indices 253 (C2FADDR), 254 (C2FDATA_LSW) and 255 (C2FDATA_MSW) over the PCIe register-write strobe.
- This block assembles each address/LSW/MSW sequence into a single 64-bit write command.
- Commands are buffered in a small FWFT FIFO and presented to FPGA application logic over a valid/ready interface.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; must be a power of two, at least 2.
- CNT_WIDTH, 16, width of the saturating overflow counter.

Ports:
- pcieClk_in  in  1  sole clock.
- pcieRstN_in  in  1  reset, asynchronous assert, active-low.
- rxRegValid_in  in  1  one-cycle strobe per host register write.
- rxRegIdx_in  in  8  register index of the host write.
- rxRegData_in  in  32  register write data.
- c2fAddr_out  out  32  command address (64-bit word index).
- c2fData_out  out  64  command data, {MSW, LSW}.
- c2fValid_out  out  1  command available at FIFO head.
- c2fReady_in  in  1  consumer accepts the head command.
- fifoLevel_out  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflowCount_out  out  CNT_WIDTH  count of commands dropped because the FIFO was full.
- seqError_out  out  1  sticky protocol-sequence error flag.
- clrErr_in  in  1  clears seqError_out and overflowCount_out.

Behaviour:
- Reset (pcieRstN_in low, asynchronous):
  - state=IDLE; addr, lsw, FIFO pointers and counters all zero.
  - Outputs: c2fValid_out=0, fifoLevel_out=0, overflowCount_out=0, seqError_out=0, c2fAddr_out=0, c2fData_out=0.
  - Reset mid-sequence discards any partial sequence and all FIFO contents.
- Only strobes with rxRegIdx_in in {253, 254, 255} are acted on; all other indices are ignored in every state.
- State machine: IDLE, GOT_ADDR, GOT_LSW.
  - idx 253, any state: addr <= data; state -> GOT_ADDR. Any held LSW is discarded without error.
  - idx 254 in GOT_ADDR: lsw <= data; state -> GOT_LSW.
  - idx 254 in GOT_LSW: lsw overwritten; state unchanged.
  - idx 254 in IDLE: ignored; seqError_out <= 1.
  - idx 255 in GOT_LSW: push {addr, data, lsw}; addr <= addr+1 (32-bit wrap, 0xFFFFFFFF -> 0); state -> GOT_ADDR.
    - Auto-increment lets the host stream further LSW/MSW pairs without rewriting the address.
  - idx 255 in IDLE or GOT_ADDR: ignored; seqError_out <= 1.
- Push acceptance:
  - A push is accepted if the FIFO is not full, or if a pop (c2fValid_out & c2fReady_in) occurs in the same cycle.
  - Otherwise the command is dropped and overflowCount_out increments, saturating at all-ones.
  - On a dropped push, addr still increments and state still moves to GOT_ADDR.
- FIFO is first-word-fall-through:
  - Latency: the command is visible on c2fValid_out/c2fAddr_out/c2fData_out on the cycle after the MSW strobe when the FIFO was empty.
  - A head entry is removed on any cycle where valid and ready are both high.
  - While c2fValid_out=1 and c2fReady_in=0, the outputs hold stable.
  - When empty, c2fValid_out=0 and the data outputs hold their last value (don't-care).
- fifoLevel_out updates registered:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Ready is ignored while valid is low; a pop never occurs when empty.
- clrErr_in priority:
  - clrErr_in clears seqError_out and overflowCount_out next cycle.
  - If a new error or overflow occurs in the same cycle, the set/increment wins: flag=1, count=1.

Test Plan:
- Stream after reset: write 253=0x00000010, 254=0xDEADBEEF, 255=0x01234567 -> one cycle after the MSW strobe, c2fValid_out=1, c2fAddr_out=0x10, c2fData_out=0x01234567DEADBEEF, fifoLevel_out=1, seqError_out=0.
- Auto-increment and wrap: 253=0xFFFFFFFF, then three LSW/MSW pairs with c2fReady_in=1 -> commands at addresses 0xFFFFFFFF, 0x0, 0x1, in order, with matching data.
- Sequence errors: 255 written directly after reset -> no command, seqError_out=1. Then 254 in IDLE after a new reset -> seqError_out=1. Then pulse clrErr_in -> seqError_out=0.
- Overflow: c2fReady_in=0, FIFO_DEPTH=8, address write then 10 LSW/MSW pairs -> fifoLevel_out=8, overflowCount_out=2. With c2fReady_in=1, exactly 8 commands drain, at addresses base+0..base+7.
- Full boundary: FIFO full, MSW strobe in the same cycle as a pop -> push accepted, fifoLevel_out stays 8, overflowCount_out unchanged.
- Mid-sequence behaviour:
  - 253, 254, then unrelated idx 7, then 253 again, then 255 -> idx 7 ignored; the LSW is discarded by the second 253, so no command is emitted and seqError_out=1.
  - Reset asserted while GOT_LSW -> all outputs return to reset values, and the next 255 produces a seqError.
